// File: rtl/div_clk_monitor.sv
// Divided-clock monitor: brings an asynchronous divided clock into the clk domain as rise/fall
// ticks, measures its period, counts its rising edges and flags loss of signal.
module div_clk_monitor #(
  parameter int SYNC_STAGES = 2,
  parameter int PW          = 16,
  parameter int CW          = 16,
  parameter int TIMEOUT     = 1000
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          div_clk_in,
  input  logic          clr,
  output logic          div_sync,
  output logic          tick_rise,
  output logic          tick_fall,
  output logic [PW-1:0] period,
  output logic          period_valid,
  output logic [CW-1:0] edge_count,
  output logic          lost
);

  localparam int            TW      = $clog2(TIMEOUT + 1);
  localparam logic [PW-1:0] PER_MAX = '1;
  localparam logic [TW-1:0] TO_MAX  = TW'(TIMEOUT);
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;
  logic [PW-1:0]          per_cnt;
  logic [TW-1:0]          to_cnt;
  logic                   armed;
  logic                   any_edge;
  logic                   timeout_hit;
  logic [PW-1:0]          period_next;

  // NOTE: non-blocking assignments make every stage sample the previous stage's old value,
  // so the chain really is SYNC_STAGES flops deep regardless of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], div_clk_in};
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  // Ticks come only from flops, so a level change yields exactly one clean pulse.
  assign div_sync  = sync_q[SYNC_STAGES-1];
  assign tick_rise = div_sync & ~prev_q;
  assign tick_fall = ~div_sync & prev_q;
  assign any_edge  = tick_rise | tick_fall;

  // Fires on the cycle the idle counter steps onto TIMEOUT, and stays asserted while it holds there.
  assign timeout_hit = (to_cnt >= TO_LAST);

  // per_cnt counts cycles since the previous rise minus one; the interval includes this cycle.
  assign period_next = (per_cnt == PER_MAX) ? PER_MAX : per_cnt + 1'b1;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      per_cnt      <= '0;
      to_cnt       <= '0;
      armed        <= 1'b0;
      period       <= '0;
      period_valid <= 1'b0;
      edge_count   <= '0;
      lost         <= 1'b0;
    end else if (clr) begin
      // clr outranks a coincident rise: that edge is neither counted nor used to arm.
      per_cnt      <= '0;
      to_cnt       <= '0;
      armed        <= 1'b0;
      period       <= '0;
      period_valid <= 1'b0;
      edge_count   <= '0;
      lost         <= 1'b0;
    end else begin
      if (tick_rise) begin
        per_cnt <= '0;
      end else if (per_cnt != PER_MAX) begin
        per_cnt <= per_cnt + 1'b1;
      end

      if (tick_rise) begin
        if (armed) begin
          period       <= period_next;
          period_valid <= 1'b1;
        end
        armed      <= 1'b1;
        edge_count <= edge_count + 1'b1;
      end

      if (any_edge) begin
        to_cnt <= '0;
        lost   <= 1'b0;
      end else begin
        if (to_cnt != TO_MAX) begin
          to_cnt <= to_cnt + 1'b1;
        end
        if (timeout_hit) begin
          // Disarm so the first rise after recovery does not measure across the dead time.
          lost         <= 1'b1;
          armed        <= 1'b0;
          period_valid <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_div_clk_monitor.sv
// Bench for div_clk_monitor: an event-level model (sample delay line, rise timestamps, idle time)
// checked against two instances every cycle, plus hand-computed checkpoints.
module tb_div_clk_monitor;

  localparam int SYNC    = 2;
  localparam int TIMEOUT = 50;
  localparam int PW_A = 16, CW_A = 16;
  localparam int PW_B = 4,  CW_B = 4;

  logic clk, reset, div_clk_in, clr;

  logic            a_div_sync, a_tick_rise, a_tick_fall, a_period_valid, a_lost;
  logic [PW_A-1:0] a_period;
  logic [CW_A-1:0] a_edge_count;
  logic            b_div_sync, b_tick_rise, b_tick_fall, b_period_valid, b_lost;
  logic [PW_B-1:0] b_period;
  logic [CW_B-1:0] b_edge_count;

  div_clk_monitor #(.SYNC_STAGES(SYNC), .PW(PW_A), .CW(CW_A), .TIMEOUT(TIMEOUT)) u_a (
    .clk(clk), .reset(reset), .div_clk_in(div_clk_in), .clr(clr),
    .div_sync(a_div_sync), .tick_rise(a_tick_rise), .tick_fall(a_tick_fall),
    .period(a_period), .period_valid(a_period_valid), .edge_count(a_edge_count), .lost(a_lost)
  );

  div_clk_monitor #(.SYNC_STAGES(SYNC), .PW(PW_B), .CW(CW_B), .TIMEOUT(TIMEOUT)) u_b (
    .clk(clk), .reset(reset), .div_clk_in(div_clk_in), .clr(clr),
    .div_sync(b_div_sync), .tick_rise(b_tick_rise), .tick_fall(b_tick_fall),
    .period(b_period), .period_valid(b_period_valid), .edge_count(b_edge_count), .lost(b_lost)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
    else n_pass++;
  endtask

  // Model: input samples delayed SYNC edges, rise/activity timestamps in edge numbers.
  logic samp[$];
  int   m_cyc, m_last_rise, m_last_act, m_diff, m_cnt;
  bit   m_armed, m_pv, m_lost;

  task automatic m_reset();
    samp.delete();
    for (int i = 0; i <= SYNC; i++) samp.push_back(1'b0);
    m_cyc = 0; m_last_rise = 0; m_last_act = 0; m_diff = 0; m_cnt = 0;
    m_armed = 1'b0; m_pv = 1'b0; m_lost = 1'b0;
  endtask

  task automatic m_step(input logic v, input logic c);
    logic tr, tf;
    tr = samp[1] & ~samp[0];
    tf = ~samp[1] & samp[0];
    m_cyc++;
    if (c) begin
      m_armed = 1'b0; m_diff = 0; m_pv = 1'b0; m_cnt = 0; m_lost = 1'b0;
      m_last_act = m_cyc;
    end else begin
      if (tr) begin
        if (m_armed) begin
          m_diff = m_cyc - m_last_rise;
          m_pv   = 1'b1;
        end
        m_armed     = 1'b1;
        m_last_rise = m_cyc;
        m_cnt++;
      end
      if (tr || tf) begin
        m_last_act = m_cyc;
        m_lost     = 1'b0;
      end else if (m_cyc - m_last_act >= TIMEOUT) begin
        m_lost  = 1'b1;
        m_armed = 1'b0;
        m_pv    = 1'b0;
      end
    end
    samp.push_back(v);
    void'(samp.pop_front());
  endtask

  initial begin
    m_reset();
    forever begin
      @(posedge clk or negedge reset);
      if (!reset) m_reset();
      else m_step(div_clk_in, clr);
    end
  end

  function automatic int sat(input int v, input int w);
    int mx;
    mx = (1 << w) - 1;
    return (v > mx) ? mx : v;
  endfunction

  // Single compare process: every negedge, both instances against the model.
  initial begin
    forever begin
      @(negedge clk);
      check("a_div_sync",   32'(a_div_sync),     32'(samp[1]));
      check("a_tick_rise",  32'(a_tick_rise),    32'(samp[1] & ~samp[0]));
      check("a_tick_fall",  32'(a_tick_fall),    32'(~samp[1] & samp[0]));
      check("a_period",     32'(a_period),       32'(sat(m_diff, PW_A)));
      check("a_valid",      32'(a_period_valid), 32'(m_pv));
      check("a_edge_count", 32'(a_edge_count),   32'(m_cnt % (1 << CW_A)));
      check("a_lost",       32'(a_lost),         32'(m_lost));
      check("b_tick_rise",  32'(b_tick_rise),    32'(samp[1] & ~samp[0]));
      check("b_period",     32'(b_period),       32'(sat(m_diff, PW_B)));
      check("b_valid",      32'(b_period_valid), 32'(m_pv));
      check("b_edge_count", 32'(b_edge_count),   32'(m_cnt % (1 << CW_B)));
      check("b_lost",       32'(b_lost),         32'(m_lost));
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic step(input logic v, input logic c);
    @(posedge clk);
    #1;
    div_clk_in = v;
    clr        = c;
  endtask

  task automatic pattern(input int hi, input int lo, input int reps);
    for (int r = 0; r < reps; r++) begin
      for (int i = 0; i < hi; i++) step(1'b1, 1'b0);
      for (int i = 0; i < lo; i++) step(1'b0, 1'b0);
    end
  endtask

  initial begin
    reset = 1'b0; div_clk_in = 1'b0; clr = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("lit_reset_period", 32'(a_period),       32'd0);
    check("lit_reset_valid",  32'(a_period_valid), 32'd0);
    check("lit_reset_count",  32'(a_edge_count),   32'd0);
    check("lit_reset_lost",   32'(a_lost),         32'd0);
    check("lit_reset_tick",   32'(a_tick_rise),    32'd0);
    @(posedge clk); #1; reset = 1'b1;
    pattern(0, 3, 1);

    // Divide-by-3, ten periods.
    pattern(2, 1, 10);
    pattern(0, 3, 1);
    @(negedge clk);
    check("lit_div3_period", 32'(a_period),       32'd3);
    check("lit_div3_valid",  32'(a_period_valid), 32'd1);
    check("lit_div3_count",  32'(a_edge_count),   32'd10);
    check("lit_div3_lost",   32'(a_lost),         32'd0);

    // Divide-by-8 then divide-by-5; CW=4 instance wraps at 16 edges.
    pattern(4, 4, 6);
    @(negedge clk);
    check("lit_div8_period",  32'(a_period),     32'd8);
    check("lit_div8_count_a", 32'(a_edge_count), 32'd16);
    check("lit_div8_wrap_b",  32'(b_edge_count), 32'd0);
    pattern(3, 2, 6);
    @(negedge clk);
    check("lit_div5_period", 32'(a_period),     32'd5);
    check("lit_div5_count",  32'(a_edge_count), 32'd22);

    // clr coincident with a rise tick: rise is not counted and does not arm.
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    step(1'b1, 1'b1);
    @(negedge clk);
    check("lit_clr_coincident_tick", 32'(a_tick_rise), 32'd1);
    step(1'b0, 1'b0);
    @(negedge clk);
    check("lit_clr_count",  32'(a_edge_count),   32'd0);
    check("lit_clr_valid",  32'(a_period_valid), 32'd0);
    check("lit_clr_period", 32'(a_period),       32'd0);
    step(1'b0, 1'b0);
    pattern(3, 2, 1);
    @(negedge clk);
    check("lit_clr_arm_only", 32'(a_period_valid), 32'd0);
    check("lit_clr_arm_cnt",  32'(a_edge_count),   32'd1);
    pattern(3, 2, 1);
    @(negedge clk);
    check("lit_clr_remeasure", 32'(a_period),       32'd5);
    check("lit_clr_valid2",    32'(a_period_valid), 32'd1);

    // Period 20: PW=4 instance saturates at 15.
    pattern(10, 10, 3);
    @(negedge clk);
    check("lit_p20_a", 32'(a_period), 32'd20);
    check("lit_p20_b", 32'(b_period), 32'd15);

    // Loss of signal, then recovery.
    pattern(0, 60, 1);
    @(negedge clk);
    check("lit_lost",        32'(a_lost),         32'd1);
    check("lit_lost_valid",  32'(a_period_valid), 32'd0);
    check("lit_lost_period", 32'(a_period),       32'd20);
    pattern(3, 3, 1);
    @(negedge clk);
    check("lit_recover_lost",  32'(a_lost),         32'd0);
    check("lit_recover_valid", 32'(a_period_valid), 32'd0);
    pattern(3, 3, 1);
    @(negedge clk);
    check("lit_recover_period", 32'(a_period),       32'd6);
    check("lit_recover_valid2", 32'(a_period_valid), 32'd1);

    // One-cycle reset mid-stream, then a fresh start.
    pattern(2, 1, 3);
    @(posedge clk); #1; reset = 1'b0; div_clk_in = 1'b0;
    @(negedge clk);
    check("lit_midrst_period", 32'(a_period),       32'd0);
    check("lit_midrst_count",  32'(a_edge_count),   32'd0);
    check("lit_midrst_valid",  32'(a_period_valid), 32'd0);
    check("lit_midrst_sync",   32'(a_div_sync),     32'd0);
    @(posedge clk); #1; reset = 1'b1;
    pattern(2, 1, 4);
    pattern(0, 3, 1);
    @(negedge clk);
    check("lit_fresh_count",  32'(a_edge_count),   32'd4);
    check("lit_fresh_period", 32'(a_period),       32'd3);
    check("lit_fresh_valid",  32'(a_period_valid), 32'd1);

    @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
